// File: rtl/btb_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : btb_update_ctrl
// Purpose  : Queues resolved-branch updates into the BTB write port and runs
//            full-table clear walks that stall fetch-side lookups.
// Revision : 1.0 - initial release
// ============================================================================
module btb_update_ctrl #(
  parameter int N     = 11,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ex_valid_i,
  output logic                     ex_ready_o,
  input  logic [31:0]              ex_pc_i,
  input  logic [31:0]              ex_target_i,
  input  logic                     ex_taken_i,
  input  logic                     ex_mispred_i,
  input  logic                     flush_req_i,
  output logic                     flush_busy_o,
  output logic                     lookup_stall_o,
  output logic                     upd_valid_o,
  input  logic                     upd_ready_i,
  output logic                     upd_clear_o,
  output logic [N-1:0]             upd_index_o,
  output logic [31:0]              upd_pc_o,
  output logic [31:0]              upd_target_o,
  output logic                     upd_taken_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [15:0]              mispred_cnt_o
);

  localparam int          PW       = $clog2(DEPTH);
  localparam int          CW       = PW + 1;
  localparam logic [0:0]  S_IDLE   = 1'b0;
  localparam logic [0:0]  S_FLUSH  = 1'b1;
  localparam logic [N-1:0] IDX_MAX = '1;

  logic [0:0]    state_q, state_d;
  logic [N-1:0]  idx_q, idx_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   mis_q, mis_d;

  logic [31:0]   pc_mem_q  [DEPTH];
  logic [31:0]   tgt_mem_q [DEPTH];
  logic          tk_mem_q  [DEPTH];

  logic w_idle, w_flush, w_drain, w_push, w_pop;

  assign w_idle  = (state_q == S_IDLE);
  assign w_flush = (state_q == S_FLUSH);
  assign w_drain = w_idle & (count_q != '0);

  // No bypass: a full FIFO refuses a beat even while its head is popping.
  assign ex_ready_o = w_idle & ~flush_req_i & (count_q < CW'(DEPTH));
  assign w_push     = ex_ready_o & ex_valid_i & (ex_mispred_i | ex_taken_i);
  assign w_pop      = w_drain & upd_ready_i;

  assign flush_busy_o   = w_flush;
  assign lookup_stall_o = w_flush | flush_req_i;
  assign upd_valid_o    = w_flush | w_drain;
  assign upd_clear_o    = w_flush;
  assign upd_index_o    = w_flush ? idx_q : '0;
  assign upd_pc_o       = w_drain ? pc_mem_q[rd_ptr_q]  : 32'd0;
  assign upd_target_o   = w_drain ? tgt_mem_q[rd_ptr_q] : 32'd0;
  assign upd_taken_o    = w_drain ? tk_mem_q[rd_ptr_q]  : 1'b0;
  assign count_o        = count_q;
  assign mispred_cnt_o  = mis_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mis_d    = mis_q;

    if (state_q == S_FLUSH) begin
      if (flush_req_i) begin
        idx_d = '0;
      end else if (upd_ready_i) begin
        if (idx_q == IDX_MAX) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + N'(1);
        end
      end
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      // Entering the walk discards the queue; a pop in this cycle still completes.
      if (flush_req_i) begin
        state_d  = S_FLUSH;
        idx_d    = '0;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end
    end

    if (w_push && ex_mispred_i && (mis_q != 16'hFFFF)) begin
      mis_d = mis_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mis_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mis_q    <= mis_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      pc_mem_q[wr_ptr_q]  <= ex_pc_i;
      tgt_mem_q[wr_ptr_q] <= ex_target_i;
      tk_mem_q[wr_ptr_q]  <= ex_taken_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_btb_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_btb_update_ctrl
// Purpose  : Self-checking bench for btb_update_ctrl (vector table, directed
//            flush sequences, randomized traffic against a queue model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_btb_update_ctrl;

  localparam int N     = 3;
  localparam int DEPTH = 4;

  logic        clk, rst;
  logic        ex_valid, ex_ready, ex_taken, ex_mispred, flush_req;
  logic [31:0] ex_pc, ex_target;
  logic        flush_busy, lookup_stall, upd_valid, upd_ready, upd_clear, upd_taken;
  logic [N-1:0] upd_index;
  logic [31:0] upd_pc, upd_target;
  logic [$clog2(DEPTH):0] count;
  logic [15:0] mispred_cnt;

  int vectors = 0;
  int miscompares = 0;

  btb_update_ctrl #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid), .ex_ready_o(ex_ready),
    .ex_pc_i(ex_pc), .ex_target_i(ex_target),
    .ex_taken_i(ex_taken), .ex_mispred_i(ex_mispred),
    .flush_req_i(flush_req), .flush_busy_o(flush_busy),
    .lookup_stall_o(lookup_stall), .upd_valid_o(upd_valid),
    .upd_ready_i(upd_ready), .upd_clear_o(upd_clear),
    .upd_index_o(upd_index), .upd_pc_o(upd_pc),
    .upd_target_o(upd_target), .upd_taken_o(upd_taken),
    .count_o(count), .mispred_cnt_o(mispred_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a plain queue of pending updates plus walk status.
  logic [31:0] q_pc[$];
  logic [31:0] q_tgt[$];
  logic        q_tk[$];
  bit          m_fl;
  int          m_idx;
  int          m_mis;

  task automatic m_reset();
    q_pc.delete(); q_tgt.delete(); q_tk.delete();
    m_fl = 0; m_idx = 0; m_mis = 0;
  endtask

  task automatic m_step();
    bit acc, push, hs;
    acc  = !m_fl && !flush_req && (q_pc.size() < DEPTH) && ex_valid;
    push = acc && (ex_mispred || ex_taken);
    hs   = upd_ready && (m_fl || q_pc.size() > 0);
    if (!m_fl) begin
      if (hs) begin
        void'(q_pc.pop_front()); void'(q_tgt.pop_front()); void'(q_tk.pop_front());
      end
      if (push) begin
        q_pc.push_back(ex_pc); q_tgt.push_back(ex_target); q_tk.push_back(ex_taken);
        if (ex_mispred && m_mis < 65535) m_mis++;
      end
      if (flush_req) begin
        m_fl = 1; m_idx = 0;
        q_pc.delete(); q_tgt.delete(); q_tk.delete();
      end
    end else if (flush_req) begin
      m_idx = 0;
    end else if (upd_ready) begin
      if (m_idx == (1 << N) - 1) begin
        m_fl = 0; m_idx = 0;
      end else begin
        m_idx++;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    bit ne;
    ne = !m_fl && (q_pc.size() > 0);
    chk("ex_ready",     ex_ready,     !m_fl && !flush_req && q_pc.size() < DEPTH);
    chk("upd_valid",    upd_valid,    m_fl || q_pc.size() > 0);
    chk("upd_clear",    upd_clear,    m_fl);
    chk("upd_index",    upd_index,    m_fl ? m_idx : 0);
    chk("upd_pc",       upd_pc,       ne ? q_pc[0]  : 32'd0);
    chk("upd_target",   upd_target,   ne ? q_tgt[0] : 32'd0);
    chk("upd_taken",    upd_taken,    ne ? q_tk[0]  : 1'b0);
    chk("flush_busy",   flush_busy,   m_fl);
    chk("lookup_stall", lookup_stall, m_fl || flush_req);
    chk("count",        count,        q_pc.size());
    chk("mispred_cnt",  mispred_cnt,  m_mis);
  endtask

  task automatic drive(input bit v, input bit tk, input bit mis, input logic [31:0] pc,
                       input logic [31:0] tgt, input bit rdy, input bit fl);
    @(negedge clk);
    ex_valid = v; ex_taken = tk; ex_mispred = mis; ex_pc = pc; ex_target = tgt;
    upd_ready = rdy; flush_req = fl;
    #1;
  endtask

  task automatic advance();
    m_step();
    @(posedge clk);
  endtask

  task automatic cyc(input bit v, input bit tk, input bit mis, input logic [31:0] pc,
                     input bit rdy, input bit fl);
    drive(v, tk, mis, pc, pc ^ 32'h5A5A_0000, rdy, fl);
    check_model();
    advance();
  endtask

  typedef struct {
    logic v, tk, mis;
    logic [31:0] pc;
    logic rdy, fl;
    logic e_rdy, e_uv;
    logic [31:0] e_pc;
    int e_cnt, e_mis;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int hs, busy;
    bit restarted;

    tbl[0]  = '{1, 1, 0, 32'h1000, 1, 0, 1, 0, 32'h0,    0, 0};
    tbl[1]  = '{1, 0, 1, 32'h1004, 1, 0, 1, 1, 32'h1000, 1, 0};
    tbl[2]  = '{1, 1, 0, 32'h1008, 1, 0, 1, 1, 32'h1004, 1, 1};
    tbl[3]  = '{0, 0, 0, 32'h0,    1, 0, 1, 1, 32'h1008, 1, 1};
    tbl[4]  = '{1, 0, 0, 32'h100C, 1, 0, 1, 0, 32'h0,    0, 1};
    tbl[5]  = '{0, 0, 0, 32'h0,    1, 0, 1, 0, 32'h0,    0, 1};
    tbl[6]  = '{1, 1, 0, 32'h2000, 0, 0, 1, 0, 32'h0,    0, 1};
    tbl[7]  = '{1, 1, 0, 32'h2004, 0, 0, 1, 1, 32'h2000, 1, 1};
    tbl[8]  = '{1, 1, 0, 32'h2008, 0, 0, 1, 1, 32'h2000, 2, 1};
    tbl[9]  = '{1, 1, 0, 32'h200C, 0, 0, 1, 1, 32'h2000, 3, 1};
    tbl[10] = '{1, 1, 0, 32'h2010, 0, 0, 0, 1, 32'h2000, 4, 1};
    tbl[11] = '{1, 1, 0, 32'h2010, 1, 0, 0, 1, 32'h2000, 4, 1};
    tbl[12] = '{0, 0, 0, 32'h0,    1, 0, 1, 1, 32'h2004, 3, 1};
    tbl[13] = '{0, 0, 0, 32'h0,    1, 0, 1, 1, 32'h2008, 2, 1};
    tbl[14] = '{0, 0, 0, 32'h0,    1, 0, 1, 1, 32'h200C, 1, 1};
    tbl[15] = '{0, 0, 0, 32'h0,    1, 0, 1, 0, 32'h0,    0, 1};

    rst = 1'b1;
    ex_valid = 0; ex_taken = 0; ex_mispred = 0; ex_pc = '0; ex_target = '0;
    upd_ready = 0; flush_req = 0;
    m_reset();

    @(negedge clk); #1;
    chk("rst_ex_ready", ex_ready, 1);
    chk("rst_stall", lookup_stall, 0);
    chk("rst_valid", upd_valid, 0);
    chk("rst_clear", upd_clear, 0);
    chk("rst_busy", flush_busy, 0);
    chk("rst_pc", upd_pc, 0);
    chk("rst_count", count, 0);
    chk("rst_mis", mispred_cnt, 0);
    flush_req = 1; #1;
    chk("rst_fl_ex_ready", ex_ready, 0);
    chk("rst_fl_stall", lookup_stall, 1);
    chk("rst_fl_busy", flush_busy, 0);
    flush_req = 0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].v, tbl[i].tk, tbl[i].mis, tbl[i].pc, tbl[i].pc + 32'h100,
            tbl[i].rdy, tbl[i].fl);
      chk($sformatf("tbl%0d_ex_ready", i), ex_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_upd_valid", i), upd_valid, tbl[i].e_uv);
      chk($sformatf("tbl%0d_upd_pc", i), upd_pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_mispred", i), mispred_cnt, tbl[i].e_mis);
      advance();
    end

    // Flush with two entries queued and the BTB always ready.
    cyc(1, 1, 0, 32'h3000, 0, 0);
    cyc(1, 0, 1, 32'h3004, 0, 0);
    cyc(0, 0, 0, 32'h0, 1, 1);
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 32'h0, 32'h0, 1, 0);
      check_model();
      if (!flush_busy) begin
        advance();
        break;
      end
      chk("flush_idx", upd_index, i);
      busy++;
      advance();
    end
    chk("flush_len", busy, 1 << N);

    // Restart the walk once it reaches index 5.
    cyc(0, 0, 0, 32'h0, 1, 1);
    hs = 0; restarted = 0;
    for (int i = 0; i < 40; i++) begin
      bit fl;
      fl = m_fl && (m_idx == 5) && !restarted;
      if (fl) restarted = 1;
      drive(0, 0, 0, 32'h0, 32'h0, 1, fl);
      check_model();
      if (!flush_busy) begin
        advance();
        break;
      end
      if (upd_valid && upd_clear && upd_ready) hs++;
      advance();
    end
    chk("restart_len", hs, 14);

    for (int i = 0; i < 3000; i++) begin
      bit rdy;
      rdy = ((i / 50) % 3 == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      cyc($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom,
          rdy, $urandom_range(0, 79) == 0);
    end

    for (int i = 0; i < 70000; i++) begin
      cyc(1, 0, 1, $urandom, 1, 0);
    end
    chk("mis_sat", mispred_cnt, 16'hFFFF);

    // Asynchronous reset in the middle of a walk.
    cyc(0, 0, 0, 32'h0, 1, 1);
    cyc(0, 0, 0, 32'h0, 1, 0);
    cyc(0, 0, 0, 32'h0, 1, 0);
    @(negedge clk);
    flush_req = 0;
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", flush_busy, 0);
    chk("arst_valid", upd_valid, 0);
    chk("arst_index", upd_index, 0);
    chk("arst_count", count, 0);
    chk("arst_mis", mispred_cnt, 0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 1, 1, 32'h4000, 1, 0);
    cyc(0, 0, 0, 32'h0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/btb_update_ctrl.md
# btb_update_ctrl

Sequences all write traffic into the branch target buffer. It queues resolved-branch updates from the execute stage and drains them one per handshake into the BTB update port. On request it also runs a full-table clear walk and stalls fetch-side lookups while the walk runs. It sits between the execute/branch-resolution unit and the BTB write port.

## Interface
- N, 11, BTB index width; the table has 2**N entries
- DEPTH, 4, update FIFO depth; power of two, at least 2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- ex_valid  in  1  resolved branch presented by execute
- ex_ready  out  1  controller accepts the ex_* beat this cycle
- ex_pc  in  32  branch instruction address
- ex_target  in  32  resolved target address
- ex_taken  in  1  branch resolved taken
- ex_mispred  in  1  branch was mispredicted
- flush_req  in  1  start a full BTB clear walk; level-sampled each cycle
- flush_busy  out  1  clear walk in progress
- lookup_stall  out  1  fetch must not use BTB lookup results
- upd_valid  out  1  BTB write request valid
- upd_ready  in  1  BTB accepts the write this cycle
- upd_clear  out  1  request is an index clear, not an address update
- upd_index  out  N  entry to clear; valid when upd_clear=1
- upd_pc  out  32  branch address for an update
- upd_target  out  32  target for an update
- upd_taken  out  1  outcome for an update
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- mispred_cnt  out  16  saturating count of mispredicted branches that were enqueued

## Operation
- States: IDLE (drain FIFO) and FLUSH (clear walk).
- Accept rule: ex_ready = (state==IDLE) & !flush_req & (count<DEPTH). No bypass, so a full FIFO stays not-ready even when it is popping in the same cycle.
- Filter: an accepted beat is pushed only if ex_mispred | ex_taken. Otherwise it is accepted and discarded, with no push and no count change.
- mispred_cnt increments on each pushed beat with ex_mispred=1 and saturates at 0xFFFF.
- IDLE drain: upd_valid = (count!=0) and upd_clear=0. upd_pc, upd_target and upd_taken come from the FIFO head. The pop happens on upd_valid & upd_ready.
- Push and pop in the same cycle leave count unchanged. The read and write pointers wrap modulo DEPTH.
- IDLE to FLUSH: on flush_req=1 in IDLE, the next edge enters FLUSH, sets the walk index to 0, and empties the FIFO (count=0, pointers reset). A pop handshake in that same cycle still completes normally.
- FLUSH behaviour:
  - upd_valid=1, upd_clear=1, upd_index=walk index.
  - On upd_ready the index increments.
  - When upd_ready is high at index 2**N-1, the next state is IDLE.
- flush_req=1 while in FLUSH restarts the walk at index 0 on the next edge.
- flush_busy = (state==FLUSH). lookup_stall = flush_busy | flush_req.
- When upd_clear=0, upd_index holds 0. When upd_clear=1, upd_pc, upd_target and upd_taken hold 0.

## Timing
- Reset values:
  - state IDLE, count 0, mispred_cnt 0.
  - upd_valid, upd_clear, flush_busy 0; upd_index, upd_pc, upd_target, upd_taken 0.
  - ex_ready = !flush_req; lookup_stall = flush_req.
- Push-to-issue latency: a beat accepted at edge k appears on upd_* after edge k if the FIFO was empty.
- Sustained throughput is one update per cycle while upd_ready=1.
- upd_* stay stable while upd_valid & !upd_ready. The BTB may stall indefinitely and no request is lost or reordered.
- Flush length is exactly 2**N upd_ready handshakes. With upd_ready held high, flush_busy is high for 2**N cycles.
- Reset asserted mid-flush or mid-drain clears everything immediately. Outputs take their reset values without waiting for a clock edge.

## Test plan
- Reset, then 3 pushes (taken, mispred, taken) with upd_ready=1 -> 3 upd beats in order one cycle later, count returns to 0, mispred_cnt=1.
- upd_ready=0 with 5 taken pushes, DEPTH=4 -> 4 accepted, ex_ready=0 on the 5th beat, count=4, upd_pc holds the first pc stable. Raise upd_ready -> drain in order.
- Not-taken, correctly predicted beat -> ex_ready=1, count stays 0, no upd_valid.
- N=3, flush_req pulse with 2 entries queued and upd_ready=1 -> FLUSH for 8 cycles, upd_index 0..7 with upd_clear=1, FIFO empty, ex_ready=0 and lookup_stall=1 throughout, then IDLE.
- flush_req reasserted at walk index 5 -> index restarts at 0, total walk of 14 handshakes. Toggle upd_ready randomly during a flush -> index advances only on handshakes.
- 70000 mispredicted pushes -> mispred_cnt saturates at 0xFFFF. Assert rst mid-flush -> flush_busy=0 and count=0 immediately.
